scm_write_packer_32to128: RTL
=============================

// Module: scm_write_packer_32to128
// PURPOSE
// - Upstream write stage for the 128b-write / 32b-read latch SCM: packs a 32b valid/ready stream into
//   128b lines and drives the SCM write port (enable, line address, data) with auto-incrementing address.
// - Fills the SCM sequentially from line 0. Stops at full until cleared. Supports write hold while readers are busy.
// PARAMETERS
// - WADDR_WIDTH  5    SCM line address width; depth = 2**WADDR_WIDTH lines
// - WDATA_WIDTH  128  SCM write width
// - IDATA_WIDTH  32   input word width. WDATA_WIDTH/IDATA_WIDTH = LANES (4) must be a power of 2.
// PORTS
// - clk          in   1            clock
// - rst          in   1            asynchronous reset, active-high
// - clear_i      in   1            sync clear: drops partial line, pending line and full; address returns to 0
// - in_valid_i   in   1            input word valid
// - in_ready_o   out  1            input word accepted when in_valid_i & in_ready_o
// - in_data_i    in   IDATA_WIDTH  input word
// - wr_hold_i    in   1            blocks write issue (e.g. SCM read in progress)
// - wr_en_o      out  1            to SCM WriteEnable
// - wr_addr_o    out  WADDR_WIDTH  to SCM WriteAddr
// - wr_data_o    out  WDATA_WIDTH  to SCM WriteData
// - full_o       out  1            all 2**WADDR_WIDTH lines written since last clear/reset
// - flush_i      in   1            only with SCM_PACKER_FLUSH_EN: close the partial line
// BEHAVIOUR
// - State: lane_q (0..LANES-1), buf_q[LANES], pending_q, addr_q, full_q.
// - Reset values: lane_q=0, buf_q=0, pending_q=0, addr_q=0, full_q=0.
//   Outputs during/after reset: wr_en_o=0, wr_addr_o=0, wr_data_o=0, full_o=0, in_ready_o=1.
// - in_ready_o = ~clear_i & ~full_q & (~pending_q | ~wr_hold_i). This is combinational.
// - Accepted word: written to buf_q[lane_q], and lane_q increments.
//   The first word of a line goes to wr_data_o[31:0] (SCM read addr {line,00}). The 4th goes to [127:96].
// - Accept at lane_q==LANES-1: lane_q wraps to 0 and pending_q is set next cycle.
//   The line is not visible as a write in the same cycle.
// - Issue: wr_en_o = pending_q & ~wr_hold_i.
//   - wr_addr_o = addr_q and wr_data_o = buf_q. Both are driven continuously from registers.
//   - On the issuing edge: pending_q clears (unless a new line completes on the same edge),
//     addr_q increments, and buf_q lanes not rewritten are zeroed.
// - Back-to-back: a word may be accepted in the issue cycle.
//   The SCM samples the old buf_q on the same edge the new lane is stored.
//   Steady-state throughput is 1 word/cycle and 1 write per LANES words.
// - Hold: while pending_q & wr_hold_i, in_ready_o=0 and wr_en_o=0, with all state frozen. Held lines are never lost.
// - Full: an issue at addr_q==2**WADDR_WIDTH-1 wraps addr_q to 0 and sets full_q.
//   - Afterwards in_ready_o=0 and no writes occur until clear_i.
// - clear_i takes priority over everything else in the same cycle.
//   - No accept (ready is low) and no issue (wr_en_o forced 0).
//   - Next cycle: lane_q=0, pending_q=0, addr_q=0, full_q=0, buf_q=0.
// - Async reset mid-line or with a pending line discards it silently. No write is issued.
// CONFIGURATION
// - SCM_PACKER_FLUSH_EN defined: adds flush_i.
//   - flush_i with lane_q>0 (after counting a same-cycle accept) closes the line.
//   - Unfilled lanes are zero and pending_q is set next cycle. lane_q returns to 0.
//   - flush_i with lane_q==0 and no accept is a no-op. flush_i is ignored while pending_q is set and the line is not yet issued.
//   - A flush of a line completing by the same accept behaves as a normal completion.
// - SCM_PACKER_FLUSH_EN undefined: no flush_i port. Only full lines are ever written.
// TESTING
// - Fill: 8 words 0x11..0x88, no hold.
//   -> wr_en_o pulses twice. Addr 0: data 0x00000044_00000033_00000022_00000011. Addr 1: 0x..88_77_66_55.
// - Hold: complete a line while wr_hold_i=1 for 5 cycles.
//   -> wr_en_o=0, in_ready_o=0 for 5 cycles. Then one write at addr 0. No words dropped.
// - Full: stream 4*32 words with valid held high.
//   -> 32 writes, addr 0..31. full_o=1 after the last. in_ready_o=0 until clear_i, then writes restart at addr 0.
// - Clear mid-line: 2 words, then clear_i together with valid.
//   -> the word is not accepted and no write occurs. The next 4 words are written at addr 0.
// - Reset mid-operation: assert rst while pending_q=1 and wr_hold_i=1.
//   -> wr_en_o never pulses. After reset, outputs are all 0 and in_ready_o=1.
// - Flush (SCM_PACKER_FLUSH_EN): 3 words 0xA,0xB,0xC then flush_i.
//   -> one write at addr 0 with data 0x00000000_0000000C_0000000B_0000000A.

Source files
------------

// File: rtl/scm_write_packer_32to128.sv
`default_nettype none
// ============================================================================
// Module   : scm_write_packer_32to128
// Purpose  : Packs a 32b valid/ready word stream into 128b lines and drives the
//            SCM write port with an auto-incrementing line address.
//            Optional flush_i port enabled by defining SCM_PACKER_FLUSH_EN.
// Revision : 1.0  initial release
// ============================================================================
module scm_write_packer_32to128 #(
    parameter int WADDR_WIDTH = 5,
    parameter int WDATA_WIDTH = 128,
    parameter int IDATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [IDATA_WIDTH-1:0] in_data_i,
    input  logic                   wr_hold_i,
    output logic                   wr_en_o,
    output logic [WADDR_WIDTH-1:0] wr_addr_o,
    output logic [WDATA_WIDTH-1:0] wr_data_o,
`ifdef SCM_PACKER_FLUSH_EN
    input  logic                   flush_i,
`endif
    output logic                   full_o
);

    localparam int c_LANES  = WDATA_WIDTH / IDATA_WIDTH;
    localparam int c_LANE_W = (c_LANES > 1) ? $clog2(c_LANES) : 1;
    localparam logic [c_LANE_W-1:0]    c_LAST_LANE = c_LANE_W'(c_LANES - 1);
    localparam logic [WADDR_WIDTH-1:0] c_LAST_ADDR = '1;

    logic [c_LANE_W-1:0]                  lane_q, lane_d;
    logic [c_LANES-1:0][IDATA_WIDTH-1:0]  buf_q, buf_d;
    logic                                 pending_q, pending_d;
    logic [WADDR_WIDTH-1:0]               addr_q, addr_d;
    logic                                 full_q, full_d;

    logic w_accept;
    logic w_issue;
    logic w_complete;
    logic w_flush_close;

    assign in_ready_o = ~clear_i & ~full_q & (~pending_q | ~wr_hold_i);
    assign w_accept   = in_valid_i & in_ready_o;
    assign w_issue    = pending_q & ~wr_hold_i & ~clear_i;
    assign w_complete = w_accept & (lane_q == c_LAST_LANE);

`ifdef SCM_PACKER_FLUSH_EN
    // A flush is honoured in the issue cycle too, since the pending line leaves on that edge.
    assign w_flush_close = flush_i & ~clear_i & ~full_q & (~pending_q | w_issue)
                         & (w_accept | (lane_q != '0));
`else
    assign w_flush_close = 1'b0;
`endif

    assign wr_en_o   = w_issue;
    assign wr_addr_o = addr_q;
    assign wr_data_o = buf_q;
    assign full_o    = full_q;

    always_comb begin
        lane_d    = lane_q;
        pending_d = pending_q;
        addr_d    = addr_q;
        full_d    = full_q;
        buf_d     = buf_q;
        if (clear_i) begin
            lane_d    = '0;
            pending_d = 1'b0;
            addr_d    = '0;
            full_d    = 1'b0;
            buf_d     = '0;
        end else begin
            if (w_issue) begin
                addr_d    = addr_q + 1'b1;
                pending_d = 1'b0;
                if (addr_q == c_LAST_ADDR) begin
                    full_d = 1'b1;
                end
            end
            if (w_complete || w_flush_close) begin
                lane_d    = '0;
                pending_d = 1'b1;
            end else if (w_accept) begin
                lane_d = lane_q + 1'b1;
            end
            // The SCM samples the old line on the issue edge, so lanes not refilled are cleared.
            for (int i = 0; i < c_LANES; i++) begin
                if (w_accept && (lane_q == c_LANE_W'(i))) begin
                    buf_d[i] = in_data_i;
                end else if (w_issue) begin
                    buf_d[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q    <= '0;
            buf_q     <= '0;
            pending_q <= 1'b0;
            addr_q    <= '0;
            full_q    <= 1'b0;
        end else begin
            lane_q    <= lane_d;
            buf_q     <= buf_d;
            pending_q <= pending_d;
            addr_q    <= addr_d;
            full_q    <= full_d;
        end
    end

endmodule
`default_nettype wire
